disp_degamma_pwl: RTL and testbench
===================================

Name: disp_degamma_pwl

Overview:
- Degamma stage directly downstream of the TCON timing/pixel source.
- Consumes the raster (vsync/hsync/de/vde/vbk/frame_end plus DW-bit R/G/B) and converts gamma-encoded pixels to linear OW-bit values.
- Conversion is a 32-segment piecewise-linear LUT shared by all three channels. The pipeline has a fixed 3-cycle latency.
- The table is double-buffered. Software writes a shadow table, and the swap into the active table happens only at frame boundaries, so a frame never mixes two curves.

Parameters:
- DW, 10, input channel width.
- OW, 12, output channel width and LUT entry width; must satisfy OW >= DW.
- SEG_BITS, 5, log2 of segment count. The table has 2^SEG_BITS+1 = 33 entries.
- FRAC_W, DW-SEG_BITS, interpolation fraction width (derived, not overridden).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- vsync_in / hsync_in / de_in / vde_in / vbk_in / frame_end_in  in  1 each  raster timing from upstream.
- r_in / g_in / b_in  in  DW  pixel data; valid when de_in=1.
- vsync_out / hsync_out / de_out / vde_out / vbk_out / frame_end_out  out  1 each  timing delayed by 3 cycles.
- r_out / g_out / b_out  out  OW  linearized pixels.
- lut_wr_en  in  1  shadow table write strobe.
- lut_wr_addr  in  6  shadow entry index, 0..32.
- lut_wr_data  in  OW  entry value.
- lut_commit  in  1  one-cycle pulse that arms a shadow-to-active swap.
- lut_pending  out  1  swap armed, not yet applied.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values:
  - All outputs 0 and all pipeline registers 0.
  - lut_pending=0.
  - Active and shadow tables hold identity: entry k = min(k<<(OW-SEG_BITS), 2^OW-1), so entry 32 = 4095 at defaults.
- Pipeline (per channel, identical logic):
  - S1: register the inputs. Segment index i = x[DW-1:FRAC_W], frac f = x[FRAC_W-1:0]. Fetch A = active[i] and B = active[i+1].
  - S2: signed diff d = B - A (OW+1 bits); product p = d*f (signed).
  - S3: y = A + ((p + 2^(FRAC_W-1)) >>> FRAC_W), registered to output.
  - y always lies between A and B, so no clamp is needed and OW bits suffice.
- Output latency is exactly 3 clocks. Every timing signal passes through a matching 3-register delay with no gaps or bubbles.
- Output data gating: r/g/b_out are forced to 0 in any cycle where de_out=0.
- Full-scale input: x = 2^DW-1 gives i=31, f=31. The output therefore never reaches entry 32 exactly; this is by design.
- Shadow writes:
  - lut_wr_en=1 with addr<=32 writes shadow[addr] at the clock edge.
  - addr>32 is ignored with no side effect.
  - The active table is never written directly.
- Commit FSM, states IDLE and ARMED:
  - IDLE -> ARMED on lut_commit; lut_pending=1 while ARMED.
  - In ARMED, on the first cycle with frame_end_in=1: copy the full shadow into active, return to IDLE, lut_pending=0.
  - If lut_commit and frame_end_in occur in the same cycle, the swap happens that cycle.
  - lut_commit while already ARMED has no effect.
- Swap timing: the swap takes effect from the pixel entering S1 on the cycle after frame_end_in. Pixels already in S1..S3 complete with the old table.
- Write and swap in the same cycle: the copy uses the shadow contents from before the write. The write still lands in shadow and becomes active at the next commit.
- Reset mid-frame: pipeline, tables and FSM return to reset values immediately. A pending commit is lost.

Optional Feature:
- Macro DEGAMMA_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - When bypass=1 at S1, that pixel's output is x<<(OW-DW), zero-filled, with the same 3-cycle latency and the same de gating.
  - bypass may toggle on any cycle, and the effect is per-pixel.
  - Commit and shadow writes continue to work normally.
- When undefined: the port is absent and the LUT path is always used.

Test Plan:
- Reset, identity table, de_in=1 with r_in=512 -> r_out=2048 three clocks later. r_in=1023 -> 4091. r_in=0 -> 0.
- Pulse de_in/hsync_in/vsync_in/frame_end_in on distinct cycles t -> each appears exactly at t+3. r_out=0 whenever de_out=0, even with nonzero r_in.
- Write shadow as inverse table (entry k = 4095-(k<<7), entry 32 = 0), then commit mid-frame:
  - lut_pending=1 and output unchanged until frame_end_in.
  - The first pixel after it, input 512, yields 2047.
  - lut_pending then drops.
- Commit and frame_end_in in the same cycle, with a write to addr 5 in that same cycle -> swap occurs, the active table excludes the new addr 5 value, and the shadow retains it.
- Write addr 40 -> no table change. Assert rst mid-frame with a commit armed -> outputs 0, lut_pending=0, identity table restored.
- (DEGAMMA_BYPASS_EN) bypass=1, r_in=1023 -> r_out=4092 at t+3. Toggle bypass every cycle -> alternating bypass and LUT results.

Source files
------------

// File: rtl/disp_degamma_pwl.sv
// disp_degamma_pwl: 3-cycle 32-segment PWL degamma with a frame-synchronous double-buffered LUT.
// Define DEGAMMA_BYPASS_EN to add a per-pixel bypass input (x << (OW-DW)).
module disp_degamma_pwl #(
  parameter int DW = 10,
  parameter int OW = 12,
  parameter int SEG_BITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync_in,
  input  logic          hsync_in,
  input  logic          de_in,
  input  logic          vde_in,
  input  logic          vbk_in,
  input  logic          frame_end_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  output logic          vsync_out,
  output logic          hsync_out,
  output logic          de_out,
  output logic          vde_out,
  output logic          vbk_out,
  output logic          frame_end_out,
  output logic [OW-1:0] r_out,
  output logic [OW-1:0] g_out,
  output logic [OW-1:0] b_out,
  input  logic          lut_wr_en,
  input  logic [5:0]    lut_wr_addr,
  input  logic [OW-1:0] lut_wr_data,
  input  logic          lut_commit,
  output logic          lut_pending
`ifdef DEGAMMA_BYPASS_EN
  ,input logic          bypass
`endif
);
  localparam int FRAC_W = DW - SEG_BITS;
  localparam int N = (1 << SEG_BITS) + 1;
  localparam int PW = OW + FRAC_W + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC_W - 1));
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state;
  logic [OW-1:0] active [N];
  logic [OW-1:0] shadow [N];
  logic [DW-1:0] x [3];
  logic [OW-1:0] bx [3];
  logic [SEG_BITS:0] ia [3], ib [3];
  logic signed [OW:0] dd [3];
  logic signed [PW-1:0] pc [3], sh [3], p2 [3];
  logic [OW-1:0] a1 [3], b1 [3], a2 [3], yc [3], y3 [3];
  logic [FRAC_W-1:0] f1 [3];
  logic [5:0] tm1, tm2, tm3;
  logic bp;
  logic swap;
`ifdef DEGAMMA_BYPASS_EN
  assign bp = bypass;
`else
  assign bp = 1'b0;
`endif
  function automatic logic [OW-1:0] ident(input int k);
    ident = (k << (OW - SEG_BITS)) > ((1 << OW) - 1) ? OW'((1 << OW) - 1) : OW'(k << (OW - SEG_BITS));
  endfunction
  assign x[0] = r_in;
  assign x[1] = g_in;
  assign x[2] = b_in;
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      ia[c] = {1'b0, x[c][DW-1:FRAC_W]};
      ib[c] = ia[c] + (SEG_BITS+1)'(1);
      bx[c] = OW'(x[c]) << (OW - DW);
      dd[c] = $signed({1'b0, b1[c]}) - $signed({1'b0, a1[c]});
      pc[c] = PW'(dd[c]) * $signed(PW'({1'b0, f1[c]}));
      sh[c] = (p2[c] + HALF) >>> FRAC_W;
      yc[c] = a2[c] + sh[c][OW-1:0];
    end
  end
  // Endpoints are fetched at S1 so pixels already in flight keep the old curve across a swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tm1 <= '0;
      tm2 <= '0;
      tm3 <= '0;
      for (int c = 0; c < 3; c++) begin
        a1[c] <= '0;
        b1[c] <= '0;
        f1[c] <= '0;
        a2[c] <= '0;
        p2[c] <= '0;
        y3[c] <= '0;
      end
    end else begin
      tm1 <= {vsync_in, hsync_in, de_in, vde_in, vbk_in, frame_end_in};
      tm2 <= tm1;
      tm3 <= tm2;
      for (int c = 0; c < 3; c++) begin
        a1[c] <= bp ? bx[c] : active[ia[c]];
        b1[c] <= bp ? bx[c] : active[ib[c]];
        f1[c] <= x[c][FRAC_W-1:0];
        a2[c] <= a1[c];
        p2[c] <= pc[c];
        y3[c] <= tm2[3] ? yc[c] : '0;
      end
    end
  end
  assign swap = frame_end_in && (state == ARMED || lut_commit);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lut_pending <= 1'b0;
      for (int k = 0; k < N; k++) begin
        active[k] <= ident(k);
        shadow[k] <= ident(k);
      end
    end else begin
      if (lut_wr_en && lut_wr_addr <= 6'(N - 1))
        shadow[lut_wr_addr] <= lut_wr_data;
      if (swap) begin
        active <= shadow;
        state <= IDLE;
        lut_pending <= 1'b0;
      end else if (lut_commit) begin
        state <= ARMED;
        lut_pending <= 1'b1;
      end
    end
  end
  assign {vsync_out, hsync_out, de_out, vde_out, vbk_out, frame_end_out} = tm3;
  assign r_out = y3[0];
  assign g_out = y3[1];
  assign b_out = y3[2];
endmodule

// File: tb/tb_disp_degamma_pwl.sv
// tb_disp_degamma_pwl: directed self-checking bench for disp_degamma_pwl.
module tb_disp_degamma_pwl;
  logic clk = 0, rst = 1;
  logic vsync_in = 0, hsync_in = 0, de_in = 0, vde_in = 0, vbk_in = 0, frame_end_in = 0;
  logic [9:0] r_in = 0, g_in = 0, b_in = 0;
  logic vsync_out, hsync_out, de_out, vde_out, vbk_out, frame_end_out;
  logic [11:0] r_out, g_out, b_out;
  logic lut_wr_en = 0, lut_commit = 0, lut_pending;
  logic [5:0] lut_wr_addr = 0;
  logic [11:0] lut_wr_data = 0;
`ifdef DEGAMMA_BYPASS_EN
  logic bypass = 0;
`endif
  int errors = 0, checks = 0;

  disp_degamma_pwl dut (
    .clk(clk), .rst(rst),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in), .vde_in(vde_in),
    .vbk_in(vbk_in), .frame_end_in(frame_end_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .de_out(de_out), .vde_out(vde_out),
    .vbk_out(vbk_out), .frame_end_out(frame_end_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .lut_commit(lut_commit), .lut_pending(lut_pending)
`ifdef DEGAMMA_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [9:0] x);
    de_in = 1;
    r_in = x;
    g_in = x;
    b_in = x;
    repeat (3) tick();
  endtask

  task automatic wr(input logic [5:0] a, input logic [11:0] d);
    lut_wr_en = 1;
    lut_wr_addr = a;
    lut_wr_data = d;
    tick();
    lut_wr_en = 0;
  endtask

  function automatic logic [5:0] sched(input int t);
    sched = {t == 5, t == 3, t == 1, t == 2, t == 4, t == 7};
  endfunction

  task automatic test_reset;
    logic [42:0] o;
    r_in = 10'd300;
    de_in = 1;
    hsync_in = 1;
    #2;
    o = {r_out, g_out, b_out, vsync_out, hsync_out, de_out, vde_out, vbk_out, frame_end_out, lut_pending};
    checks++;
    if (o !== 43'd0) begin $display("FAIL reset_outputs: got %h expected 0", o); errors++; end
    tick();
    tick();
    o = {r_out, g_out, b_out, vsync_out, hsync_out, de_out, vde_out, vbk_out, frame_end_out, lut_pending};
    checks++;
    if (o !== 43'd0) begin $display("FAIL reset_held: got %h expected 0", o); errors++; end
    rst = 0;
    de_in = 0;
    hsync_in = 0;
    r_in = 0;
  endtask

  task automatic test_identity;
    de_in = 1;
    r_in = 10'd512;
    g_in = 10'd1023;
    b_in = 10'd0;
    repeat (3) tick();
    checks++;
    if (r_out !== 12'd2048) begin $display("FAIL id_r512: got %0d expected 2048", r_out); errors++; end
    checks++;
    if (g_out !== 12'd4091) begin $display("FAIL id_g1023: got %0d expected 4091", g_out); errors++; end
    checks++;
    if (b_out !== 12'd0) begin $display("FAIL id_b0: got %0d expected 0", b_out); errors++; end
    drive_pix(10'd100);
    checks++;
    if (r_out !== 12'd400) begin $display("FAIL id_100: got %0d expected 400", r_out); errors++; end
    de_in = 0;
    repeat (3) tick();
  endtask

  task automatic test_timing;
    logic [5:0] got, exp;
    for (int cyc = 0; cyc < 12; cyc++) begin
      {vsync_in, hsync_in, de_in, vde_in, vbk_in, frame_end_in} = sched(cyc);
      r_in = 10'd777;
      tick();
      exp = sched(cyc - 2);
      got = {vsync_out, hsync_out, de_out, vde_out, vbk_out, frame_end_out};
      checks++;
      if (got !== exp) begin $display("FAIL timing_c%0d: got %b expected %b", cyc, got, exp); errors++; end
      checks++;
      if (r_out !== (exp[3] ? 12'd3108 : 12'd0)) begin
        $display("FAIL gate_c%0d: got %0d expected %0d", cyc, r_out, exp[3] ? 3108 : 0); errors++;
      end
    end
  endtask

  task automatic test_commit;
    de_in = 1;
    r_in = 10'd512;
    for (int k = 0; k <= 32; k++) wr(6'(k), k == 32 ? 12'd0 : 12'(4095 - (k << 7)));
    lut_commit = 1;
    tick();
    lut_commit = 0;
    checks++;
    if (lut_pending !== 1'b1) begin $display("FAIL pend_armed: got %b expected 1", lut_pending); errors++; end
    repeat (4) tick();
    checks++;
    if (r_out !== 12'd2048) begin $display("FAIL pend_old: got %0d expected 2048", r_out); errors++; end
    checks++;
    if (lut_pending !== 1'b1) begin $display("FAIL pend_hold: got %b expected 1", lut_pending); errors++; end
    frame_end_in = 1;
    tick();
    frame_end_in = 0;
    checks++;
    if (lut_pending !== 1'b0) begin $display("FAIL pend_drop: got %b expected 0", lut_pending); errors++; end
    tick();
    tick();
    checks++;
    if (r_out !== 12'd2048) begin $display("FAIL swap_inflight: got %0d expected 2048", r_out); errors++; end
    tick();
    checks++;
    if (r_out !== 12'd2047) begin $display("FAIL swap_first: got %0d expected 2047", r_out); errors++; end
    drive_pix(10'd100);
    checks++;
    if (r_out !== 12'd3695) begin $display("FAIL inv_100: got %0d expected 3695", r_out); errors++; end
    drive_pix(10'd1023);
    checks++;
    if (b_out !== 12'd4) begin $display("FAIL inv_1023: got %0d expected 4", b_out); errors++; end
  endtask

  task automatic test_same_cycle;
    wr(6'd4, 12'd2000);
    lut_wr_en = 1;
    lut_wr_addr = 6'd5;
    lut_wr_data = 12'd1000;
    lut_commit = 1;
    frame_end_in = 1;
    tick();
    lut_wr_en = 0;
    lut_commit = 0;
    frame_end_in = 0;
    checks++;
    if (lut_pending !== 1'b0) begin $display("FAIL same_pend: got %b expected 0", lut_pending); errors++; end
    drive_pix(10'd128);
    checks++;
    if (r_out !== 12'd2000) begin $display("FAIL same_swapped: got %0d expected 2000", r_out); errors++; end
    drive_pix(10'd160);
    checks++;
    if (r_out !== 12'd3455) begin $display("FAIL same_oldwr: got %0d expected 3455", r_out); errors++; end
    lut_commit = 1;
    frame_end_in = 1;
    tick();
    lut_commit = 0;
    frame_end_in = 0;
    drive_pix(10'd160);
    checks++;
    if (g_out !== 12'd1000) begin $display("FAIL same_shadow: got %0d expected 1000", g_out); errors++; end
  endtask

  task automatic test_bad_addr;
    wr(6'd40, 12'd1234);
    lut_commit = 1;
    frame_end_in = 1;
    tick();
    lut_commit = 0;
    frame_end_in = 0;
    drive_pix(10'd224);
    checks++;
    if (r_out !== 12'd3199) begin $display("FAIL bad_e7: got %0d expected 3199", r_out); errors++; end
    drive_pix(10'd256);
    checks++;
    if (r_out !== 12'd3071) begin $display("FAIL bad_e8: got %0d expected 3071", r_out); errors++; end
    drive_pix(10'd128);
    checks++;
    if (r_out !== 12'd2000) begin $display("FAIL bad_e4: got %0d expected 2000", r_out); errors++; end
  endtask

  task automatic test_reset_mid;
    logic [39:0] o;
    lut_commit = 1;
    tick();
    lut_commit = 0;
    checks++;
    if (lut_pending !== 1'b1) begin $display("FAIL mid_armed: got %b expected 1", lut_pending); errors++; end
    de_in = 1;
    hsync_in = 1;
    r_in = 10'd1023;
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    o = {r_out, g_out, b_out, de_out, hsync_out, vde_out, lut_pending};
    checks++;
    if (o !== 40'd0) begin $display("FAIL mid_reset: got %h expected 0", o); errors++; end
    tick();
    rst = 0;
    hsync_in = 0;
    frame_end_in = 1;
    tick();
    frame_end_in = 0;
    checks++;
    if (lut_pending !== 1'b0) begin $display("FAIL mid_lost: got %b expected 0", lut_pending); errors++; end
    drive_pix(10'd512);
    checks++;
    if (r_out !== 12'd2048) begin $display("FAIL mid_id512: got %0d expected 2048", r_out); errors++; end
    drive_pix(10'd160);
    checks++;
    if (r_out !== 12'd640) begin $display("FAIL mid_id160: got %0d expected 640", r_out); errors++; end
  endtask

`ifdef DEGAMMA_BYPASS_EN
  task automatic test_bypass;
    bypass = 1;
    drive_pix(10'd1023);
    checks++;
    if (r_out !== 12'd4092) begin $display("FAIL byp_1023: got %0d expected 4092", r_out); errors++; end
    for (int cyc = 0; cyc < 8; cyc++) begin
      bypass = cyc[0];
      tick();
      if (cyc >= 2) begin
        checks++;
        if (r_out !== (cyc[0] ? 12'd4092 : 12'd4091)) begin
          $display("FAIL byp_toggle_c%0d: got %0d expected %0d", cyc, r_out, cyc[0] ? 4092 : 4091); errors++;
        end
      end
    end
    bypass = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_timing();
    test_commit();
    test_same_cycle();
    test_bad_addr();
    test_reset_mid();
`ifdef DEGAMMA_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
